multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Main control FSM for the multi-cycle RV32I core. Classifies the latched IR opcode and sequences fetch/decode/execute/memory/writeback.
//  Drives write enables, mux selects and a req/ready handshake to the single shared memory port. Sits between the IR and the datapath.
// PARAMETERS
//  MEM_WAIT_MAX  16  cycles a mem_req may wait for mem_ready before abort (>=2)
//  WDOG_W        5   watchdog counter width; must satisfy 2**WDOG_W > MEM_WAIT_MAX
// PORTS
//  clk           in   1  core clock, rising edge
//  rst_n         in   1  asynchronous, active-low reset
//  opcode        in   7  IR[6:0]; valid from DECODE onward
//  branch_taken  in   1  ALU compare result; sampled in BR
//  mem_ready     in   1  memory completes the current request this cycle
//  mem_req       out  1  memory request; held until mem_ready
//  mem_we        out  1  1 = store (valid with mem_req)
//  mem_addr_sel  out  1  0 = PC, 1 = ALU result
//  ir_we         out  1  load IR from memory read data
//  pc_we         out  1  update PC
//  pc_src        out  2  0 = PC+4, 1 = PC+imm, 2 = ALU result (jalr, LSB cleared in datapath)
//  reg_we        out  1  register file write
//  wb_sel        out  2  0 = ALU, 1 = mem data, 2 = PC+4, 3 = imm (lui)
//  alu_a_sel     out  2  0 = rs1, 1 = PC, 2 = zero
//  alu_b_sel     out  1  0 = rs2, 1 = imm
//  alu_op_cls    out  2  0 = add, 1 = funct-driven (R/I), 2 = compare (branch)
//  instr_retired out  1  one-cycle pulse per completed instruction
//  mem_err       out  1  one-cycle pulse on watchdog abort
//  state_o       out  4  current state, debug
// BEHAVIOUR
//  - All outputs decoded from registered state/class (Moore); mem_req/ready handshake qualifies transitions only.
//  - rst_n low: state = IDLE, class/counter cleared; every output 0. Reset mid-transfer drops mem_req immediately (async).
//  - IDLE -> FETCH unconditionally on the first clock after rst_n rises.
//  - FETCH: mem_req=1, mem_addr_sel=0. If mem_ready: ir_we=1 -> DECODE; else stay.
//  - DECODE: latch op class (LOAD 3, STORE 35, OPIMM 19, OP 51, LUI 55, AUIPC 23, BRANCH 99, JALR 103, JAL 111, else ILLEGAL).
//    Next: LOAD/STORE -> ADDR; OP/OPIMM/LUI/AUIPC -> EXEC; BRANCH -> BR; JAL/JALR -> JUMP; ILLEGAL -> see CONFIGURATION.
//  - EXEC: OP: a=rs1,b=rs2,cls=1; OPIMM: a=rs1,b=imm,cls=1; AUIPC: a=PC,b=imm,cls=0; LUI: no ALU use. -> WB.
//  - ADDR: a=rs1, b=imm, cls=0 -> MEM.
//  - MEM: mem_req=1, mem_addr_sel=1, mem_we=(STORE). On mem_ready: LOAD -> WB; STORE -> FETCH with pc_we=1, pc_src=0, retire.
//  - WB: reg_we=1; wb_sel = 1 (LOAD), 3 (LUI), else 0; pc_we=1, pc_src=0; retire; -> FETCH.
//  - BR: a=rs1, b=rs2, cls=2; pc_we=1, pc_src = branch_taken ? 1 : 0; retire; -> FETCH.
//  - JUMP: reg_we=1, wb_sel=2; pc_we=1, pc_src = JAL ? 1 : 2; retire; -> FETCH.
//  - instr_retired asserted in the cycle the retiring state's pc_we is high (STORE: in the MEM cycle where mem_ready=1).
//  - Latency (zero-wait memory): ALU/LUI/AUIPC 4 cycles, load 5, store 4, branch/jump 3.
//  - Watchdog: counter clears on entry to FETCH/MEM and on mem_ready; increments each cycle mem_req && !mem_ready.
//    When it equals MEM_WAIT_MAX-1 with mem_ready still low: mem_err=1 that cycle, -> FETCH, no pc_we/ir_we/reg_we,
//    no retire (fetch retried at same PC). mem_ready in that same cycle wins: normal completion, no mem_err.
//  - x0 writes are the register file's concern; controller still asserts reg_we.
// CONFIGURATION
//  ILLEGAL_OP_TRAP_EN defined: ILLEGAL class -> TRAP; TRAP holds all outputs 0 and output trap=1 (extra port, 1 bit)
//    until reset; no retire.
//  Not defined: ILLEGAL executes as NOP: DECODE -> WB with reg_we=0, pc_we=1, pc_src=0, retire. No trap port.
// STRUCTURE
//  ctrl_pkg: state_t enum (IDLE, FETCH, DECODE, EXEC, ADDR, MEM, WB, BR, JUMP, TRAP), opcode localparams,
//    op_class_t enum, pc_src/wb_sel/alu_a_sel/alu_op_cls encodings.
//  Sub-module op_classify: combinational opcode -> op_class_t, instantiated once; class register kept in multicycle_ctrl.
// TESTING
//  - Reset: rst_n low mid-MEM with mem_req=1 -> mem_req=0 same cycle; after release IDLE 1 cycle, then FETCH mem_req=1.
//  - addi (op 19), mem_ready always 1 -> FETCH,DECODE,EXEC,WB; reg_we/wb_sel=0 in cycle 4; instr_retired once.
//  - lw (op 3), data ready after 3 waits -> MEM holds mem_req, mem_addr_sel=1, mem_we=0 for 4 cycles; WB wb_sel=1.
//  - beq (op 99) branch_taken=1 -> BR pc_src=1; with branch_taken=0 -> pc_src=0; both 3 cycles, one retire.
//  - jalr (op 103) -> JUMP wb_sel=2, pc_src=2; jal (op 111) -> pc_src=1.
//  - mem_ready held 0 in FETCH, MEM_WAIT_MAX=4 -> mem_err pulse on 4th wait cycle, back to FETCH, no ir_we/retire.
//  - opcode 7'h7F: with ILLEGAL_OP_TRAP_EN trap=1 stuck until reset; without -> NOP, pc_src=0, one retire.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control path:
// FSM states, opcode values, instruction classes and datapath select codes.
package ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, EXEC, ADDR, MEM, WB, BR, JUMP, TRAP
  } state_t;

  // ILLEGAL is first so a cleared class register reads as "no valid class".
  typedef enum logic [3:0] {
    CLS_ILLEGAL, CLS_LOAD, CLS_STORE, CLS_OPIMM, CLS_OP,
    CLS_LUI, CLS_AUIPC, CLS_BRANCH, CLS_JALR, CLS_JAL
  } op_class_t;

  localparam logic [6:0] OPC_LOAD   = 7'd3;
  localparam logic [6:0] OPC_STORE  = 7'd35;
  localparam logic [6:0] OPC_OPIMM  = 7'd19;
  localparam logic [6:0] OPC_OP     = 7'd51;
  localparam logic [6:0] OPC_LUI    = 7'd55;
  localparam logic [6:0] OPC_AUIPC  = 7'd23;
  localparam logic [6:0] OPC_BRANCH = 7'd99;
  localparam logic [6:0] OPC_JALR   = 7'd103;
  localparam logic [6:0] OPC_JAL    = 7'd111;

  localparam logic [1:0] PC_SRC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_SRC_IMM   = 2'd1;
  localparam logic [1:0] PC_SRC_ALU   = 2'd2;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;
  localparam logic [1:0] WB_SEL_IMM = 2'd3;

  localparam logic [1:0] ALU_A_RS1  = 2'd0;
  localparam logic [1:0] ALU_A_PC   = 2'd1;
  localparam logic [1:0] ALU_A_ZERO = 2'd2;

  localparam logic ALU_B_RS2 = 1'b0;
  localparam logic ALU_B_IMM = 1'b1;

  localparam logic [1:0] ALU_CLS_ADD   = 2'd0;
  localparam logic [1:0] ALU_CLS_FUNCT = 2'd1;
  localparam logic [1:0] ALU_CLS_CMP   = 2'd2;

endpackage

// File: rtl/op_classify.sv
// Combinational RV32I major-opcode classifier; unknown opcodes map to ILLEGAL.
module op_classify
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_t  op_class
);

  always_comb begin
    case (opcode)
      OPC_LOAD:   op_class = CLS_LOAD;
      OPC_STORE:  op_class = CLS_STORE;
      OPC_OPIMM:  op_class = CLS_OPIMM;
      OPC_OP:     op_class = CLS_OP;
      OPC_LUI:    op_class = CLS_LUI;
      OPC_AUIPC:  op_class = CLS_AUIPC;
      OPC_BRANCH: op_class = CLS_BRANCH;
      OPC_JALR:   op_class = CLS_JALR;
      OPC_JAL:    op_class = CLS_JAL;
      default:    op_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core (Moore outputs, memory watchdog).
// Optional ILLEGAL_OP_TRAP_EN: illegal opcodes lock into TRAP and raise trap; otherwise they retire as NOPs.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 16,
  parameter int WDOG_W       = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       reg_we,
  output logic [1:0] wb_sel,
  output logic [1:0] alu_a_sel,
  output logic       alu_b_sel,
  output logic [1:0] alu_op_cls,
  output logic       instr_retired,
  output logic       mem_err,
`ifdef ILLEGAL_OP_TRAP_EN
  output logic       trap,
`endif
  output logic [3:0] state_o
);

  state_t            state, state_next;
  op_class_t         op_cls, dec_cls;
  logic [WDOG_W-1:0] wdog, wdog_next;
  logic              mem_wait, wdog_abort;

  op_classify u_op_classify (
    .opcode   (opcode),
    .op_class (dec_cls)
  );

  // FETCH and MEM are the only states that drive mem_req.
  assign mem_wait   = ((state == FETCH) || (state == MEM)) && !mem_ready;
  assign wdog_abort = mem_wait && (wdog == WDOG_W'(MEM_WAIT_MAX - 1));
  assign wdog_next  = (mem_wait && !wdog_abort) ? wdog + WDOG_W'(1) : '0;
  assign state_o    = state;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_cls <= CLS_ILLEGAL;
      wdog   <= '0;
    end else begin
      state <= state_next;
      wdog  <= wdog_next;
      if (state == DECODE) op_cls <= dec_cls;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_next    = state;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr_sel  = 1'b0;
    ir_we         = 1'b0;
    pc_we         = 1'b0;
    pc_src        = PC_SRC_PLUS4;
    reg_we        = 1'b0;
    wb_sel        = WB_SEL_ALU;
    alu_a_sel     = ALU_A_RS1;
    alu_b_sel     = ALU_B_RS2;
    alu_op_cls    = ALU_CLS_ADD;
    instr_retired = 1'b0;
    mem_err       = 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
    trap          = 1'b0;
`endif
    case (state)
      IDLE: state_next = FETCH;
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we      = 1'b1;
          state_next = DECODE;
        end else if (wdog_abort) begin
          mem_err = 1'b1;
        end
      end
      DECODE: begin
        case (dec_cls)
          CLS_LOAD, CLS_STORE:                       state_next = ADDR;
          CLS_OP, CLS_OPIMM, CLS_LUI, CLS_AUIPC:     state_next = EXEC;
          CLS_BRANCH:                                state_next = BR;
          CLS_JAL, CLS_JALR:                         state_next = JUMP;
`ifdef ILLEGAL_OP_TRAP_EN
          default:                                   state_next = TRAP;
`else
          default:                                   state_next = WB;
`endif
        endcase
      end
      EXEC: begin
        case (op_cls)
          CLS_OP:    alu_op_cls = ALU_CLS_FUNCT;
          CLS_OPIMM: begin
            alu_b_sel  = ALU_B_IMM;
            alu_op_cls = ALU_CLS_FUNCT;
          end
          CLS_AUIPC: begin
            alu_a_sel = ALU_A_PC;
            alu_b_sel = ALU_B_IMM;
          end
          default: ;
        endcase
        state_next = WB;
      end
      ADDR: begin
        alu_b_sel  = ALU_B_IMM;
        state_next = MEM;
      end
      MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (op_cls == CLS_STORE);
        if (mem_ready) begin
          if (op_cls == CLS_STORE) begin
            pc_we         = 1'b1;
            instr_retired = 1'b1;
            state_next    = FETCH;
          end else begin
            state_next = WB;
          end
        end else if (wdog_abort) begin
          mem_err    = 1'b1;
          state_next = FETCH;
        end
      end
      WB: begin
        // An illegal opcode reaching WB is a NOP: it advances PC but writes nothing.
        reg_we        = (op_cls != CLS_ILLEGAL);
        wb_sel        = (op_cls == CLS_LOAD) ? WB_SEL_MEM :
                        (op_cls == CLS_LUI)  ? WB_SEL_IMM : WB_SEL_ALU;
        pc_we         = 1'b1;
        instr_retired = 1'b1;
        state_next    = FETCH;
      end
      BR: begin
        alu_op_cls    = ALU_CLS_CMP;
        pc_we         = 1'b1;
        pc_src        = branch_taken ? PC_SRC_IMM : PC_SRC_PLUS4;
        instr_retired = 1'b1;
        state_next    = FETCH;
      end
      JUMP: begin
        reg_we        = 1'b1;
        wb_sel        = WB_SEL_PC4;
        pc_we         = 1'b1;
        pc_src        = (op_cls == CLS_JAL) ? PC_SRC_IMM : PC_SRC_ALU;
        instr_retired = 1'b1;
        state_next    = FETCH;
      end
      TRAP: begin
`ifdef ILLEGAL_OP_TRAP_EN
        trap = 1'b1;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus queues per-cycle expected control words, a negedge monitor compares.
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic       req, we, mas, irwe, pcwe;
    logic [1:0] pcsrc;
    logic       regwe;
    logic [1:0] wbsel, asel;
    logic       bsel;
    logic [1:0] cls;
    logic       ret, err, tr;
  } ctl_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic       branch_taken = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, mem_addr_sel, ir_we, pc_we, reg_we, alu_b_sel;
  logic       instr_retired, mem_err, trap_s;
  logic [1:0] pc_src, wb_sel, alu_a_sel, alu_op_cls;
  logic [3:0] state_o;

  ctl_t  exp_q[$];
  string name_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_WAIT_MAX(4), .WDOG_W(3)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .branch_taken  (branch_taken),
    .mem_ready     (mem_ready),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr_sel  (mem_addr_sel),
    .ir_we         (ir_we),
    .pc_we         (pc_we),
    .pc_src        (pc_src),
    .reg_we        (reg_we),
    .wb_sel        (wb_sel),
    .alu_a_sel     (alu_a_sel),
    .alu_b_sel     (alu_b_sel),
    .alu_op_cls    (alu_op_cls),
    .instr_retired (instr_retired),
    .mem_err       (mem_err),
`ifdef ILLEGAL_OP_TRAP_EN
    .trap          (trap_s),
`endif
    .state_o       (state_o)
  );

`ifndef ILLEGAL_OP_TRAP_EN
  assign trap_s = 1'b0;
`endif

  // Hand-written expected control words, one helper per state.
  function automatic ctl_t c_idle();
    ctl_t e = '0;
    e.st = IDLE;
    return e;
  endfunction

  function automatic ctl_t c_fetch(input logic irwe, input logic err);
    ctl_t e = '0;
    e.st = FETCH; e.req = 1'b1; e.irwe = irwe; e.err = err;
    return e;
  endfunction

  function automatic ctl_t c_decode();
    ctl_t e = '0;
    e.st = DECODE;
    return e;
  endfunction

  function automatic ctl_t c_exec(input logic [1:0] asel, input logic bsel, input logic [1:0] cls);
    ctl_t e = '0;
    e.st = EXEC; e.asel = asel; e.bsel = bsel; e.cls = cls;
    return e;
  endfunction

  function automatic ctl_t c_addr();
    ctl_t e = '0;
    e.st = ADDR; e.bsel = 1'b1;
    return e;
  endfunction

  function automatic ctl_t c_mem(input logic we, input logic ret, input logic err);
    ctl_t e = '0;
    e.st = MEM; e.req = 1'b1; e.mas = 1'b1; e.we = we;
    e.pcwe = ret; e.ret = ret; e.err = err;
    return e;
  endfunction

  function automatic ctl_t c_wb(input logic regwe, input logic [1:0] wbsel);
    ctl_t e = '0;
    e.st = WB; e.regwe = regwe; e.wbsel = wbsel; e.pcwe = 1'b1; e.ret = 1'b1;
    return e;
  endfunction

  function automatic ctl_t c_br(input logic [1:0] pcsrc);
    ctl_t e = '0;
    e.st = BR; e.cls = 2'd2; e.pcwe = 1'b1; e.pcsrc = pcsrc; e.ret = 1'b1;
    return e;
  endfunction

  function automatic ctl_t c_jump(input logic [1:0] pcsrc);
    ctl_t e = '0;
    e.st = JUMP; e.regwe = 1'b1; e.wbsel = 2'd2; e.pcwe = 1'b1; e.pcsrc = pcsrc; e.ret = 1'b1;
    return e;
  endfunction

  function automatic ctl_t c_trap();
    ctl_t e = '0;
    e.st = TRAP; e.tr = 1'b1;
    return e;
  endfunction

  task automatic step(input logic rst, input logic rdy, input logic [6:0] op,
                      input logic bt, input ctl_t e, input string nm);
    @(posedge clk);
    #1;
    rst_n        = rst;
    mem_ready    = rdy;
    opcode       = op;
    branch_taken = bt;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: every negedge with an expectation pending, compare the whole control word.
  initial begin
    ctl_t  e, act;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        nm  = name_q.pop_front();
        act = {state_o, mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, reg_we,
               wb_sel, alu_a_sel, alu_b_sel, alu_op_cls, instr_retired, mem_err, trap_s};
        n_cmp++;
        if (act !== e) begin
          n_err++;
          $display("FAIL %s: got %b required %b (st,req,we,mas,irwe,pcwe,pcsrc,regwe,wbsel,asel,bsel,cls,ret,err,trap)",
                   nm, act, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset held, then released: one IDLE cycle, then FETCH.
    step(1'b0, 1'b0, 7'd0, 1'b0, c_idle(), "rst_hold0");
    step(1'b0, 1'b0, 7'd0, 1'b0, c_idle(), "rst_hold1");
    step(1'b1, 1'b1, 7'd19, 1'b0, c_idle(), "rst_release_idle");

    // addi
    step(1'b1, 1'b1, 7'd19, 1'b0, c_fetch(1'b1, 1'b0), "addi_fetch");
    step(1'b1, 1'b1, 7'd19, 1'b0, c_decode(), "addi_decode");
    step(1'b1, 1'b1, 7'd19, 1'b0, c_exec(2'd0, 1'b1, 2'd1), "addi_exec");
    step(1'b1, 1'b1, 7'd19, 1'b0, c_wb(1'b1, 2'd0), "addi_wb");

    // R-type
    step(1'b1, 1'b1, 7'd51, 1'b0, c_fetch(1'b1, 1'b0), "op_fetch");
    step(1'b1, 1'b1, 7'd51, 1'b0, c_decode(), "op_decode");
    step(1'b1, 1'b1, 7'd51, 1'b0, c_exec(2'd0, 1'b0, 2'd1), "op_exec");
    step(1'b1, 1'b1, 7'd51, 1'b0, c_wb(1'b1, 2'd0), "op_wb");

    // lui, auipc
    step(1'b1, 1'b1, 7'd55, 1'b0, c_fetch(1'b1, 1'b0), "lui_fetch");
    step(1'b1, 1'b1, 7'd55, 1'b0, c_decode(), "lui_decode");
    step(1'b1, 1'b1, 7'd55, 1'b0, c_exec(2'd0, 1'b0, 2'd0), "lui_exec");
    step(1'b1, 1'b1, 7'd55, 1'b0, c_wb(1'b1, 2'd3), "lui_wb");
    step(1'b1, 1'b1, 7'd23, 1'b0, c_fetch(1'b1, 1'b0), "auipc_fetch");
    step(1'b1, 1'b1, 7'd23, 1'b0, c_decode(), "auipc_decode");
    step(1'b1, 1'b1, 7'd23, 1'b0, c_exec(2'd1, 1'b1, 2'd0), "auipc_exec");
    step(1'b1, 1'b1, 7'd23, 1'b0, c_wb(1'b1, 2'd0), "auipc_wb");

    // lw with 3 wait cycles: ready arrives as the watchdog reaches its limit and wins.
    step(1'b1, 1'b1, 7'd3, 1'b0, c_fetch(1'b1, 1'b0), "lw_fetch");
    step(1'b1, 1'b1, 7'd3, 1'b0, c_decode(), "lw_decode");
    step(1'b1, 1'b1, 7'd3, 1'b0, c_addr(), "lw_addr");
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 7'd3, 1'b0, c_mem(1'b0, 1'b0, 1'b0), $sformatf("lw_mem_wait%0d", i));
    step(1'b1, 1'b1, 7'd3, 1'b0, c_mem(1'b0, 1'b0, 1'b0), "lw_mem_ready");
    step(1'b1, 1'b1, 7'd3, 1'b0, c_wb(1'b1, 2'd1), "lw_wb");

    // sw, zero wait
    step(1'b1, 1'b1, 7'd35, 1'b0, c_fetch(1'b1, 1'b0), "sw_fetch");
    step(1'b1, 1'b1, 7'd35, 1'b0, c_decode(), "sw_decode");
    step(1'b1, 1'b1, 7'd35, 1'b0, c_addr(), "sw_addr");
    step(1'b1, 1'b1, 7'd35, 1'b0, c_mem(1'b1, 1'b1, 1'b0), "sw_mem_retire");

    // beq taken / not taken
    step(1'b1, 1'b1, 7'd99, 1'b1, c_fetch(1'b1, 1'b0), "beq_t_fetch");
    step(1'b1, 1'b1, 7'd99, 1'b1, c_decode(), "beq_t_decode");
    step(1'b1, 1'b1, 7'd99, 1'b1, c_br(2'd1), "beq_taken_br");
    step(1'b1, 1'b1, 7'd99, 1'b0, c_fetch(1'b1, 1'b0), "beq_n_fetch");
    step(1'b1, 1'b1, 7'd99, 1'b0, c_decode(), "beq_n_decode");
    step(1'b1, 1'b1, 7'd99, 1'b0, c_br(2'd0), "beq_not_taken_br");

    // jalr / jal
    step(1'b1, 1'b1, 7'd103, 1'b0, c_fetch(1'b1, 1'b0), "jalr_fetch");
    step(1'b1, 1'b1, 7'd103, 1'b0, c_decode(), "jalr_decode");
    step(1'b1, 1'b1, 7'd103, 1'b0, c_jump(2'd2), "jalr_jump");
    step(1'b1, 1'b1, 7'd111, 1'b0, c_fetch(1'b1, 1'b0), "jal_fetch");
    step(1'b1, 1'b1, 7'd111, 1'b0, c_decode(), "jal_decode");
    step(1'b1, 1'b1, 7'd111, 1'b0, c_jump(2'd1), "jal_jump");

    // FETCH watchdog abort on 4th wait, then the retry must get a fresh budget.
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 7'd19, 1'b0, c_fetch(1'b0, 1'b0), $sformatf("wd_fetch_wait%0d", i));
    step(1'b1, 1'b0, 7'd19, 1'b0, c_fetch(1'b0, 1'b1), "wd_fetch_abort");
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 7'd19, 1'b0, c_fetch(1'b0, 1'b0), $sformatf("wd_retry_wait%0d", i));
    step(1'b1, 1'b1, 7'd19, 1'b0, c_fetch(1'b1, 1'b0), "wd_retry_ready");
    step(1'b1, 1'b1, 7'd19, 1'b0, c_decode(), "wd_retry_decode");
    step(1'b1, 1'b1, 7'd19, 1'b0, c_exec(2'd0, 1'b1, 2'd1), "wd_retry_exec");
    step(1'b1, 1'b1, 7'd19, 1'b0, c_wb(1'b1, 2'd0), "wd_retry_wb");

    // Store aborted in MEM: no retire, back to FETCH.
    step(1'b1, 1'b1, 7'd35, 1'b0, c_fetch(1'b1, 1'b0), "swab_fetch");
    step(1'b1, 1'b1, 7'd35, 1'b0, c_decode(), "swab_decode");
    step(1'b1, 1'b1, 7'd35, 1'b0, c_addr(), "swab_addr");
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 7'd35, 1'b0, c_mem(1'b1, 1'b0, 1'b0), $sformatf("swab_mem_wait%0d", i));
    step(1'b1, 1'b0, 7'd35, 1'b0, c_mem(1'b1, 1'b0, 1'b1), "swab_mem_abort");
    step(1'b1, 1'b0, 7'd3, 1'b0, c_fetch(1'b0, 1'b0), "swab_back_fetch");

    // Reset asserted mid-cycle in MEM: mem_req must drop before the next edge.
    step(1'b1, 1'b1, 7'd3, 1'b0, c_fetch(1'b1, 1'b0), "rmid_fetch");
    step(1'b1, 1'b1, 7'd3, 1'b0, c_decode(), "rmid_decode");
    step(1'b1, 1'b1, 7'd3, 1'b0, c_addr(), "rmid_addr");
    step(1'b1, 1'b0, 7'd3, 1'b0, c_mem(1'b0, 1'b0, 1'b0), "rmid_mem");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    exp_q.push_back(c_idle());
    name_q.push_back("rmid_async_drop");
    step(1'b0, 1'b0, 7'd3, 1'b0, c_idle(), "rmid_hold");
    step(1'b1, 1'b0, 7'd3, 1'b0, c_idle(), "rmid_release_idle");
    step(1'b1, 1'b1, 7'h7F, 1'b0, c_fetch(1'b1, 1'b0), "rmid_fetch_again");

    // Illegal opcode 7'h7F
    step(1'b1, 1'b1, 7'h7F, 1'b0, c_decode(), "ill_decode");
`ifdef ILLEGAL_OP_TRAP_EN
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 7'h7F, 1'b0, c_trap(), $sformatf("ill_trap%0d", i));
    step(1'b0, 1'b1, 7'd19, 1'b0, c_idle(), "ill_trap_reset");
    step(1'b1, 1'b1, 7'd19, 1'b0, c_idle(), "ill_trap_release");
    step(1'b1, 1'b1, 7'd19, 1'b0, c_fetch(1'b1, 1'b0), "ill_after_fetch");
`else
    step(1'b1, 1'b1, 7'h7F, 1'b0, c_wb(1'b0, 2'd0), "ill_nop_wb");
    step(1'b1, 1'b1, 7'd19, 1'b0, c_fetch(1'b1, 1'b0), "ill_after_fetch");
`endif

    // Drain with a bounded wait.
    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
